// File: rtl/bnn_weight_streamer_if.sv
// Weight byte stream into the BNN weight streamer (valid/ready).
// Latency: none; pure signal bundle.
// Backpressure: slave drops in_ready when its buffer is full or the frame quota is reached.
interface bnn_weight_streamer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bnn_weight_streamer.sv
// Streams NUM_NEURONS weight bytes to the BNN receiver as nibble beats on its uio lane.
// Latency: RST_CYCLES receiver-reset cycles + 1 fetch cycle before the first beat, then 2 beats/byte.
// Backpressure: in_ready low when FIFO full/idle/quota met; sink_ena low stalls the current beat.
module bnn_weight_streamer #(
    parameter int NUM_NEURONS = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int RST_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    bnn_weight_streamer_if.slave   in_if,
    input  logic                   sink_ena_i,
    output logic [7:0]             uio_drive_o,
    output logic                   sink_rst_n_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [3:0]             byte_count_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRST,
        S_FETCH,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [7:0]    cur_byte_q;
    logic [3:0]    byte_count_q;
    logic [4:0]    byte_count_d;
    logic [4:0]    accepted_q;
    logic [RW-1:0] rst_cnt_q;

    logic       fifo_empty;
    logic       fifo_full;
    logic [7:0] fifo_head;
    logic       in_ready;
    logic       push;
    logic       pop;
    logic       last_byte;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

    // Ready depends only on registered state, so there is no input-to-ready path
    // and a full FIFO only accepts again after a pop has freed a slot.
    assign in_ready = (state_q != S_IDLE) && (state_q != S_DONE) && !fifo_full &&
                      (accepted_q < 5'(NUM_NEURONS));
    assign in_if.in_ready = in_ready;
    assign push = in_if.in_valid && in_ready;

    // Count is widened so a 16-neuron frame still detects its last byte.
    assign byte_count_d = {1'b0, byte_count_q} + 5'd1;
    assign last_byte    = (byte_count_d == 5'(NUM_NEURONS));

    assign pop = ((state_q == S_FETCH) && !fifo_empty) ||
                 ((state_q == S_HI) && sink_ena_i && !last_byte && !fifo_empty);

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= in_if.in_data;
        end
    end

    // FIFO pointers; flushed at every accepted start so a frame never sees stale bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if ((state_q == S_IDLE) && start_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Frame sequencer: receiver reset pulse, then low/high nibble beats per byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_byte_q   <= 8'h00;
            byte_count_q <= 4'd0;
            accepted_q   <= 5'd0;
            rst_cnt_q    <= '0;
        end else begin
            if (push) begin
                accepted_q <= accepted_q + 5'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q      <= S_SRST;
                        byte_count_q <= 4'd0;
                        accepted_q   <= 5'd0;
                        rst_cnt_q    <= '0;
                    end
                end
                S_SRST: begin
                    if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                        state_q <= S_FETCH;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!fifo_empty) begin
                        cur_byte_q <= fifo_head;
                        state_q    <= S_LO;
                    end
                end
                S_LO: begin
                    if (sink_ena_i) begin
                        state_q <= S_HI;
                    end
                end
                S_HI: begin
                    if (sink_ena_i) begin
                        byte_count_q <= byte_count_d[3:0];
                        if (last_byte) begin
                            state_q <= S_DONE;
                        end else if (!fifo_empty) begin
                            // Back-to-back byte: load_en stays high across the boundary.
                            cur_byte_q <= fifo_head;
                            state_q    <= S_LO;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state only; load_en is high solely in LO/HI.
    always_comb begin
        uio_drive_o  = 8'h00;
        sink_rst_n_o = 1'b1;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        byte_count_o = byte_count_q;
        case (state_q)
            S_SRST: begin
                sink_rst_n_o = 1'b0;
                busy_o       = 1'b1;
            end
            S_FETCH: begin
                busy_o = 1'b1;
            end
            S_LO: begin
                uio_drive_o = {cur_byte_q[3:0], 1'b1, 3'b000};
                busy_o      = 1'b1;
            end
            S_HI: begin
                uio_drive_o = {cur_byte_q[7:4], 1'b1, 3'b000};
                busy_o      = 1'b1;
            end
            S_DONE: begin
                frame_done_o = 1'b1;
            end
            default: begin
                uio_drive_o = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Directed bench for bnn_weight_streamer with a behavioural receiver attached.
// Latency: checks beat sequence, receiver-reset length and frame completion.
// Backpressure: exercises sink_ena stalls, sparse input and byte over-offer.
module tb_bnn_weight_streamer;

    localparam int NN  = 12;
    localparam int RST = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sink_ena;
    logic [7:0] uio_drive;
    logic       sink_rst_n;
    logic       busy;
    logic       frame_done;
    logic [3:0] byte_count;

    bnn_weight_streamer_if u_if ();

    bnn_weight_streamer #(
        .NUM_NEURONS (NN),
        .FIFO_DEPTH  (4),
        .RST_CYCLES  (RST)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .in_if        (u_if),
        .sink_ena_i   (sink_ena),
        .uio_drive_o  (uio_drive),
        .sink_rst_n_o (sink_rst_n),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .byte_count_o (byte_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] vec [14];
    logic [3:0] nib_q [$];
    int         srst_cycles;
    int         done_pulses;
    int         le_gaps;
    int         beats;
    int         fed;
    bit         abort = 1'b0;

    // Behavioural receiver: low nibble then high nibble per weight, index cleared by rst_n.
    logic [7:0] rx_w [16];
    logic [3:0] rx_idx;
    logic       rx_ph;
    logic [3:0] rx_lo;
    always @(posedge clk) begin
        if (!sink_rst_n) begin
            rx_idx <= 4'd0;
            rx_ph  <= 1'b0;
            for (int k = 0; k < 16; k++) rx_w[k] <= 8'h00;
        end else if (sink_ena && uio_drive[3]) begin
            if (!rx_ph) begin
                rx_lo <= uio_drive[7:4];
            end else begin
                rx_w[rx_idx] <= {uio_drive[7:4], rx_lo};
                rx_idx       <= rx_idx + 4'd1;
            end
            rx_ph <= ~rx_ph;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_drive(input int k);
        logic [7:0] b;
        b = vec[k / 2];
        return (k % 2 == 0) ? {b[3:0], 4'h8} : {b[7:4], 4'h8};
    endfunction

    task automatic load_set(input int sel);
        if (sel == 0)
            vec = '{8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'hFF, 8'h00,
                    8'h83, 8'h0C, 8'h30, 8'h80, 8'h11, 8'h22};
        else
            vec = '{8'h5A, 8'hC3, 8'h01, 8'h10, 8'hFE, 8'hEF, 8'h77, 8'h88,
                    8'h99, 8'h66, 8'h3C, 8'hA0, 8'h11, 8'h22};
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers n bytes, one every (gap+1) cycles at best; fed counts accepted bytes.
    task automatic feed(input int n, input int gap, input int budget);
        int cyc = 0;
        int g   = 0;
        fed = 0;
        while (fed < n && cyc < budget && !abort) begin
            if (g > 0) begin
                g--;
                u_if.in_valid = 1'b0;
            end else begin
                u_if.in_valid = 1'b1;
                u_if.in_data  = vec[fed];
                if (u_if.in_ready) begin
                    fed++;
                    g = gap;
                end
            end
            @(negedge clk);
            cyc++;
        end
        u_if.in_valid = 1'b0;
    endtask

    task automatic monitor(input int stall_beat, input int abort_beat,
                           input int start_beat, input int budget);
        int cyc   = 0;
        int stall = 0;
        nib_q.delete();
        srst_cycles = 0;
        done_pulses = 0;
        le_gaps     = 0;
        beats       = 0;
        while (done_pulses == 0 && cyc < budget && !abort) begin
            start = (beats == start_beat);
            if (!sink_rst_n) srst_cycles++;
            if (frame_done) done_pulses++;
            if (uio_drive[3]) begin
                if (beats == abort_beat) begin
                    chk("abort_beat_drive", uio_drive, exp_drive(beats));
                    reset = 1'b1;
                    abort = 1'b1;
                end else if (beats == stall_beat && stall < 3) begin
                    sink_ena = 1'b0;
                    stall++;
                    chk("stall_drive", uio_drive, exp_drive(beats));
                    chk("stall_count", byte_count, beats / 2);
                end else begin
                    sink_ena = 1'b1;
                    nib_q.push_back(uio_drive[7:4]);
                    beats++;
                end
            end else begin
                sink_ena = 1'b1;
                if (beats > 0 && beats < 2 * NN) le_gaps++;
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        sink_ena = 1'b1;
    endtask

    task automatic frame_checks(input string t);
        chk({t, "_done_pulses"}, done_pulses, 1);
        chk({t, "_srst_cycles"}, srst_cycles, RST);
        chk({t, "_beats"}, nib_q.size(), 2 * NN);
        for (int i = 0; i < NN; i++) begin
            if (nib_q.size() == 2 * NN)
                chk($sformatf("%s_nib_byte%0d", t, i), {nib_q[2*i+1], nib_q[2*i]}, vec[i]);
            chk($sformatf("%s_rx_w%0d", t, i), rx_w[i], vec[i]);
        end
        chk({t, "_byte_count_idle"}, byte_count, NN);
        chk({t, "_busy_idle"}, busy, 0);
        chk({t, "_done_idle"}, frame_done, 0);
        chk({t, "_uio_idle"}, uio_drive, 8'h00);
    endtask

    task automatic reset_checks(input string t);
        chk({t, "_uio"}, uio_drive, 8'h00);
        chk({t, "_rst_n"}, sink_rst_n, 1);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_done"}, frame_done, 0);
        chk({t, "_count"}, byte_count, 0);
        chk({t, "_ready"}, u_if.in_ready, 0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        sink_ena      = 1'b1;
        u_if.in_valid = 1'b0;
        u_if.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        reset = 1'b0;
        @(negedge clk);
        u_if.in_valid = 1'b1;
        @(negedge clk);
        chk("idle_ready_with_valid", u_if.in_ready, 0);
        u_if.in_valid = 1'b0;

        // Full-rate frame with receiver attached.
        load_set(0);
        start_frame();
        fork
            feed(NN, 0, 200);
            monitor(-1, -1, -1, 200);
        join
        frame_checks("t1");
        chk("t1_le_gaps", le_gaps, 0);
        chk("t1_fed", fed, NN);
        repeat (3) @(negedge clk);
        chk("t1_count_holds", byte_count, NN);

        // Receiver stalls for 3 cycles during the high nibble of byte 5.
        load_set(1);
        start_frame();
        chk("t3_count_cleared", byte_count, 0);
        fork
            feed(NN, 0, 200);
            monitor(9, -1, -1, 200);
        join
        frame_checks("t3");

        // Sparse input: one byte every 5 cycles; start pulse mid-frame must be ignored.
        load_set(0);
        start_frame();
        fork
            feed(NN, 4, 300);
            monitor(-1, -1, 6, 300);
        join
        frame_checks("t4");
        chk("t4_fetch_gaps_seen", le_gaps > 0, 1);

        // Over-offer: 14 bytes presented, only 12 may be taken.
        load_set(1);
        start_frame();
        fork
            feed(14, 0, 80);
            monitor(-1, -1, -1, 200);
        join
        frame_checks("t5");
        chk("t5_accepted", fed, NN);

        // Reset during the low nibble of byte 3, then a clean frame.
        load_set(0);
        start_frame();
        fork
            feed(NN, 0, 200);
            monitor(-1, 4, -1, 200);
        join
        reset_checks("t6_abort");
        chk("t6_abort_seen", abort, 1);
        @(negedge clk);
        reset = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        load_set(1);
        start_frame();
        fork
            feed(NN, 0, 200);
            monitor(-1, -1, -1, 200);
        join
        frame_checks("t6_restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
